// File: rtl/connect4_win_checker_if.sv
// connect4_win_checker_if
//   Request/result bundle between the game-control FSM (master) and the
//   win checker (slave). The win_mask signal exists only when the macro
//   WIN_MASK_EN is defined.
interface connect4_win_checker_if #(
  parameter int BOARD_DIM = 4
);
  localparam int CELLS     = BOARD_DIM * BOARD_DIM;
  localparam int NUM_LINES = 2 * BOARD_DIM + 2;
  localparam int LINE_W    = $clog2(NUM_LINES);

  // Request side
  logic              start;
  logic [CELLS-1:0]  gameboard;
  logic [CELLS-1:0]  players_cells;

  // Result side
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [1:0]        result;
  logic [LINE_W-1:0] win_line;
`ifdef WIN_MASK_EN
  logic [CELLS-1:0]  win_mask;
`endif

  // Game-control side: issues checks and consumes results
  modport master (
    output start, gameboard, players_cells,
    input  busy, done, result_valid, result, win_line
`ifdef WIN_MASK_EN
    , input win_mask
`endif
  );

  // Win checker side
  modport slave (
    input  start, gameboard, players_cells,
    output busy, done, result_valid, result, win_line
`ifdef WIN_MASK_EN
    , output win_mask
`endif
  );
endinterface

// File: rtl/connect4_win_checker.sv
// connect4_win_checker
//   Scans a BOARD_DIM x BOARD_DIM board one line per clock after each move
//   and reports P1 win, P2 win, draw or game-continues.
//   Line order: rows 0..D-1, columns D..2D-1, main diagonal 2D, anti
//   diagonal 2D+1. The first winning line in that order ends the scan.
//   Optional feature: define WIN_MASK_EN to add the win_mask output, a
//   per-cell map of the winning line.
module connect4_win_checker #(
  parameter int BOARD_DIM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  connect4_win_checker_if.slave bus
);

  localparam int CELLS     = BOARD_DIM * BOARD_DIM;
  localparam int NUM_LINES = 2 * BOARD_DIM + 2;
  localparam int LINE_W    = $clog2(NUM_LINES);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } result_t;

  // Cell map of line k: bit (row*D + col) is set for each of its D cells.
  function automatic logic [CELLS-1:0] line_mask(input int k);
    logic [CELLS-1:0] m;
    m = '0;
    for (int j = 0; j < BOARD_DIM; j++) begin
      if (k < BOARD_DIM)
        m[k * BOARD_DIM + j] = 1'b1;                       // row k
      else if (k < 2 * BOARD_DIM)
        m[j * BOARD_DIM + (k - BOARD_DIM)] = 1'b1;         // column k-D
      else if (k == 2 * BOARD_DIM)
        m[j * BOARD_DIM + j] = 1'b1;                       // main diagonal
      else
        m[j * BOARD_DIM + (BOARD_DIM - 1 - j)] = 1'b1;     // anti diagonal
    end
    return m;
  endfunction

  // State and snapshot registers
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CELLS-1:0]  r_board;
  logic [CELLS-1:0]  r_owner;
  logic [LINE_W-1:0] r_line;

  // Result registers
  result_t           r_result;
  logic [LINE_W-1:0] r_win_line;
  logic              r_result_valid;
`ifdef WIN_MASK_EN
  logic [CELLS-1:0]  r_win_mask;
`endif

  // Line evaluation and FSM control
  logic [CELLS-1:0]  w_line_mask;
  logic              w_occupied;
  logic              w_all_p1;
  logic              w_all_p2;
  logic              w_line_win;
  logic              w_board_full;
  logic              w_last_line;
  logic              w_accept;
  logic              w_finish;
  logic              w_busy;
  logic              w_done;
  result_t           w_final_result;

  // Select the cell map of the line addressed by the scan counter.
  // NOTE: every variable written in always_comb gets a default first, so a
  // path that skips an assignment cannot infer a latch.
  always_comb begin
    w_line_mask = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (r_line == LINE_W'(k)) w_line_mask = line_mask(k);
    end
  end

  // A line wins when all its cells are filled and share one owner bit.
  assign w_occupied   = (r_board & w_line_mask) == w_line_mask;
  assign w_all_p2     = (r_owner & w_line_mask) == w_line_mask;
  assign w_all_p1     = (r_owner & w_line_mask) == '0;
  assign w_line_win   = w_occupied && (w_all_p1 || w_all_p2);
  assign w_board_full = &r_board;
  assign w_last_line  = (r_line == LAST_LINE);

  // Outcome written when the scan ends: winner of the current line, or
  // draw/none once the last line has been checked without a win.
  always_comb begin
    w_final_result = RES_NONE;
    if (w_line_win)
      w_final_result = w_all_p2 ? RES_P2 : RES_P1;
    else if (w_board_full)
      w_final_result = RES_DRAW;
  end

  // FSM state register.
  // NOTE: reset is synchronous here, so it appears inside the clocked body
  // and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (w_line_win || w_last_line) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot capture, scan counter and result registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_board        <= '0;
      r_owner        <= '0;
      r_line         <= '0;
      r_result       <= RES_NONE;
      r_win_line     <= '0;
      r_result_valid <= 1'b0;
`ifdef WIN_MASK_EN
      r_win_mask     <= '0;
`endif
    end else if (w_accept) begin
      // The scan works only on the snapshot, so later input changes are
      // invisible until the next accepted start.
      r_board        <= bus.gameboard;
      r_owner        <= bus.players_cells;
      r_line         <= '0;
      r_result       <= RES_NONE;
      r_win_line     <= '0;
      r_result_valid <= 1'b0;
`ifdef WIN_MASK_EN
      r_win_mask     <= '0;
`endif
    end else if (w_finish) begin
      r_result       <= w_final_result;
      r_win_line     <= w_line_win ? r_line : '0;
      r_result_valid <= 1'b1;
`ifdef WIN_MASK_EN
      r_win_mask     <= w_line_win ? w_line_mask : '0;
`endif
    end else if (r_state == S_SCAN) begin
      r_line         <= r_line + LINE_W'(1);
    end
  end

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;
  assign bus.win_line     = r_win_line;
`ifdef WIN_MASK_EN
  assign bus.win_mask     = r_win_mask;
`endif

endmodule
